// File: rtl/hangman_pkg.sv
// Shared constants and FSM state types for the hangman keyboard front end.
package hangman_pkg;

  // Letter codes loaded onto char/guess; 0 means no letter yet.
  localparam logic [4:0] CH_NONE = 5'd0;
  localparam logic [4:0] CH_A = 5'd1;
  localparam logic [4:0] CH_B = 5'd2;
  localparam logic [4:0] CH_C = 5'd3;
  localparam logic [4:0] CH_D = 5'd4;
  localparam logic [4:0] CH_E = 5'd5;
  localparam logic [4:0] CH_F = 5'd6;
  localparam logic [4:0] CH_G = 5'd7;
  localparam logic [4:0] CH_H = 5'd8;
  localparam logic [4:0] CH_I = 5'd9;
  localparam logic [4:0] CH_J = 5'd10;
  localparam logic [4:0] CH_K = 5'd11;
  localparam logic [4:0] CH_L = 5'd12;
  localparam logic [4:0] CH_M = 5'd13;
  localparam logic [4:0] CH_N = 5'd14;
  localparam logic [4:0] CH_O = 5'd15;
  localparam logic [4:0] CH_P = 5'd16;
  localparam logic [4:0] CH_Q = 5'd17;
  localparam logic [4:0] CH_R = 5'd18;
  localparam logic [4:0] CH_S = 5'd19;
  localparam logic [4:0] CH_T = 5'd20;
  localparam logic [4:0] CH_U = 5'd21;
  localparam logic [4:0] CH_V = 5'd22;
  localparam logic [4:0] CH_W = 5'd23;
  localparam logic [4:0] CH_X = 5'd24;
  localparam logic [4:0] CH_Y = 5'd25;
  localparam logic [4:0] CH_Z = 5'd26;

  // Scan-code set 2 prefixes and control keys.
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  // Bit-level frame receiver states.
  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  // Byte-sequence states: plain, after F0, after E0, after E0 F0.
  typedef enum logic [1:0] {
    BY_NORM,
    BY_BRK,
    BY_EXT,
    BY_EXTBRK
  } byte_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame
// FSM and inter-edge timeout. Reports one accepted byte or one error per frame.
module ps2_frame_rx
  import hangman_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   sdat;

  frame_state_t state;
  logic [7:0]   shreg;
  logic [2:0]   bit_cnt;
  logic         par_bit;
  logic [CW-1:0] tcnt;

  logic stop_ok;
  logic timeout_hit;

  // Synchronize both pins; reset to the idle-high line level so reset
  // release never fabricates a falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign sdat = dat_sync[SYNC_STAGES-1];

  // Odd parity over data+parity, stop bit must be high.
  assign stop_ok     = sdat & (^{shreg, par_bit});
  assign timeout_hit = (state != FR_IDLE) && !fall &&
                       (tcnt == CW'(TIMEOUT_CYCLES - 1));

  // Frame result is flagged in the stop-sample cycle so the top can register
  // its strobes one cycle later.
  assign rx_byte    = shreg;
  assign byte_valid = fall && (state == FR_STOP) && stop_ok;
  assign err        = (fall && (state == FR_STOP) && !stop_ok) || timeout_hit;

  // Frame FSM and timeout counter; every edge clears the timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= FR_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else if (fall) begin
      tcnt <= '0;
      case (state)
        FR_IDLE: begin
          if (!sdat) begin
            state   <= FR_DATA;
            bit_cnt <= '0;
          end
        end
        FR_DATA: begin
          shreg   <= {sdat, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= FR_PARITY;
        end
        FR_PARITY: begin
          par_bit <= sdat;
          state   <= FR_STOP;
        end
        FR_STOP: state <= FR_IDLE;
        default: state <= FR_IDLE;
      endcase
    end else if (state == FR_IDLE) begin
      tcnt <= '0;
    end else if (timeout_hit) begin
      state <= FR_IDLE;
      shreg <= '0;
      tcnt  <= '0;
    end else begin
      tcnt <= tcnt + CW'(1);
    end
  end

endmodule

// File: rtl/ps2_char_decoder.sv
// PS/2 keyboard to hangman letter decoder: byte-sequence FSM (make, F0 break,
// E0 extended), typematic suppression via a held-key register, and strobes.
module ps2_char_decoder
  import hangman_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int TIMEOUT_CYCLES = CLK_HZ / 1000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [4:0] char,
  output logic       char_valid,
  output logic       enter,
  output logic       backspace,
  output logic       frame_err
);

  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        err;
  logic [4:0]  letter;
  logic [7:0]  held;
  byte_state_t bstate;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .err       (err)
  );

  function automatic logic [4:0] scan_to_letter(input logic [7:0] sc);
    logic [4:0] r;
    r = CH_NONE;
    case (sc)
      8'h1C: r = CH_A;  8'h32: r = CH_B;  8'h21: r = CH_C;  8'h23: r = CH_D;
      8'h24: r = CH_E;  8'h2B: r = CH_F;  8'h34: r = CH_G;  8'h33: r = CH_H;
      8'h43: r = CH_I;  8'h3B: r = CH_J;  8'h42: r = CH_K;  8'h4B: r = CH_L;
      8'h3A: r = CH_M;  8'h31: r = CH_N;  8'h44: r = CH_O;  8'h4D: r = CH_P;
      8'h15: r = CH_Q;  8'h2D: r = CH_R;  8'h1B: r = CH_S;  8'h2C: r = CH_T;
      8'h3C: r = CH_U;  8'h2A: r = CH_V;  8'h1D: r = CH_W;  8'h22: r = CH_X;
      8'h35: r = CH_Y;  8'h1A: r = CH_Z;
      default: r = CH_NONE;
    endcase
    return r;
  endfunction

  assign letter = scan_to_letter(rx_byte);

  // Byte FSM with registered strobes; a make equal to held is auto-repeat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bstate     <= BY_NORM;
      held       <= '0;
      char       <= CH_NONE;
      char_valid <= 1'b0;
      enter      <= 1'b0;
      backspace  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      char_valid <= 1'b0;
      enter      <= 1'b0;
      backspace  <= 1'b0;
      frame_err  <= err;
      if (err) begin
        bstate <= BY_NORM;
      end else if (byte_valid) begin
        case (bstate)
          BY_NORM: begin
            if (rx_byte == SC_BREAK) begin
              bstate <= BY_BRK;
            end else if (rx_byte == SC_EXT) begin
              bstate <= BY_EXT;
            end else if (rx_byte != held) begin
              held <= rx_byte;
              if (letter != CH_NONE) begin
                char       <= letter;
                char_valid <= 1'b1;
              end else if (rx_byte == SC_ENTER) begin
                enter <= 1'b1;
              end else if (rx_byte == SC_BKSP) begin
                backspace <= 1'b1;
              end
            end
          end
          BY_BRK: begin
            // Release of a key other than held (rollover) leaves held alone.
            if (rx_byte == held) held <= '0;
            bstate <= BY_NORM;
          end
          BY_EXT:    bstate <= (rx_byte == SC_BREAK) ? BY_EXTBRK : BY_NORM;
          BY_EXTBRK: bstate <= BY_NORM;
          default:   bstate <= BY_NORM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_char_decoder.sv
// Bench for ps2_char_decoder: directed vector table, hand-written timeout and
// reset corner cases, then random frames against a scan-code sequence model.
module tb_ps2_char_decoder;

  localparam int TO   = 300;
  localparam int HALF = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [4:0] char;
  logic       char_valid, enter, backspace, frame_err;

  always #5 clk = ~clk;

  ps2_char_decoder #(
    .CLK_HZ        (50000000),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .char      (char),
    .char_valid(char_valid),
    .enter     (enter),
    .backspace (backspace),
    .frame_err (frame_err)
  );

  int errors = 0;
  int checks = 0;

  // Cumulative pulse counters; stimulus takes snapshots and diffs.
  int n_cv = 0, n_en = 0, n_bs = 0, n_fe = 0, n_multi = 0;
  always @(negedge clk) begin
    if (char_valid) n_cv++;
    if (enter) n_en++;
    if (backspace) n_bs++;
    if (frame_err) n_fe++;
    if (int'(char_valid) + int'(enter) + int'(backspace) + int'(frame_err) > 1) n_multi++;
  end

  int s_cv, s_en, s_bs, s_fe;
  int d_cv, d_en, d_bs, d_fe;
  int lat;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic snap();
    s_cv = n_cv; s_en = n_en; s_bs = n_bs; s_fe = n_fe;
  endtask

  task automatic diff();
    d_cv = n_cv - s_cv; d_en = n_en - s_en; d_bs = n_bs - s_bs; d_fe = n_fe - s_fe;
  endtask

  function automatic logic [10:0] mk_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  // Drive frame bits [from, to); bit 10 (stop) also measures output latency.
  task automatic send_bits(input logic [10:0] bits, input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      ps2_dat = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
          @(negedge clk);
          if (lat < 0 && (char_valid | enter | backspace | frame_err)) lat = k;
        end
        repeat (HALF - 8) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    snap();
    send_bits(mk_bits(b, bad_par, bad_stop), 0, 11);
    repeat (6) @(negedge clk);
    diff();
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sc_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                              8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                              8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                              8'h35, 8'h1A};
  logic [7:0] m_held;
  bit         m_f0, m_e0;
  int         m_char;
  int         e_cv, e_en, e_bs, e_fe;

  function automatic int letter_of(input logic [7:0] b);
    for (int i = 0; i < 26; i++) if (sc_tab[i] == b) return i + 1;
    return 0;
  endfunction

  task automatic model(input logic [7:0] b, input bit bad);
    int l;
    e_cv = 0; e_en = 0; e_bs = 0; e_fe = 0;
    if (bad) begin
      e_fe = 1; m_f0 = 0; m_e0 = 0;
    end else if (m_e0) begin
      if (!m_f0 && b == 8'hF0) m_f0 = 1;
      else begin m_e0 = 0; m_f0 = 0; end
    end else if (m_f0) begin
      if (b == m_held) m_held = 8'h00;
      m_f0 = 0;
    end else if (b == 8'hF0) m_f0 = 1;
    else if (b == 8'hE0) m_e0 = 1;
    else if (b != m_held) begin
      m_held = b;
      l = letter_of(b);
      if (l != 0) begin m_char = l; e_cv = 1; end
      else if (b == 8'h5A) e_en = 1;
      else if (b == 8'h66) e_bs = 1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         bad_stop;
    int         cv, en, bs, fe, ch;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input logic [7:0] d, input bit bp, input bit bs_,
                             input int cv, input int en, input int bs, input int fe, input int ch);
    vec_t r;
    r.data = d; r.bad_par = bp; r.bad_stop = bs_;
    r.cv = cv; r.en = en; r.bs = bs; r.fe = fe; r.ch = ch;
    return r;
  endfunction

  initial begin
    logic [10:0] fb;
    logic [7:0]  rb;
    int          r;
    bit          bad;

    // reset and idle
    resetn = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_char", int'(char), 0);
    chk("reset_pulses", int'(char_valid) + int'(enter) + int'(backspace) + int'(frame_err), 0);
    resetn = 1'b1;
    snap();
    repeat (1000) @(negedge clk);
    diff();
    chk("idle_pulses", d_cv + d_en + d_bs + d_fe, 0);
    chk("idle_char", int'(char), 0);

    tbl.push_back(v(8'h1C, 0, 0, 1, 0, 0, 0, 1));   // A make
    tbl.push_back(v(8'hF0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(8'h1C, 0, 0, 0, 0, 0, 0, 1));   // A release
    tbl.push_back(v(8'h2D, 0, 0, 1, 0, 0, 0, 18));  // R make
    tbl.push_back(v(8'h2D, 0, 0, 0, 0, 0, 0, 18));  // typematic
    tbl.push_back(v(8'h2D, 0, 0, 0, 0, 0, 0, 18));
    tbl.push_back(v(8'hF0, 0, 0, 0, 0, 0, 0, 18));
    tbl.push_back(v(8'h2D, 0, 0, 0, 0, 0, 0, 18));
    tbl.push_back(v(8'h2D, 0, 0, 1, 0, 0, 0, 18));  // second press
    tbl.push_back(v(8'h24, 1, 0, 0, 0, 0, 1, 18));  // bad parity
    tbl.push_back(v(8'h24, 0, 0, 1, 0, 0, 0, 5));
    tbl.push_back(v(8'hE0, 0, 0, 0, 0, 0, 0, 5));
    tbl.push_back(v(8'h75, 0, 0, 0, 0, 0, 0, 5));
    tbl.push_back(v(8'hE0, 0, 0, 0, 0, 0, 0, 5));
    tbl.push_back(v(8'hF0, 0, 0, 0, 0, 0, 0, 5));
    tbl.push_back(v(8'h75, 0, 0, 0, 0, 0, 0, 5));
    tbl.push_back(v(8'h66, 0, 0, 0, 0, 1, 0, 5));   // backspace
    tbl.push_back(v(8'h5A, 0, 0, 0, 1, 0, 0, 5));   // enter
    tbl.push_back(v(8'h1C, 0, 1, 0, 0, 0, 1, 5));   // bad stop
    tbl.push_back(v(8'h1C, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(v(8'h22, 0, 0, 1, 0, 0, 0, 24));  // rollover to X
    tbl.push_back(v(8'hF0, 0, 0, 0, 0, 0, 0, 24));
    tbl.push_back(v(8'h1C, 0, 0, 0, 0, 0, 0, 24));  // release A, held stays X
    tbl.push_back(v(8'h22, 0, 0, 0, 0, 0, 0, 24));  // still auto-repeat
    tbl.push_back(v(8'hF0, 0, 0, 0, 0, 0, 0, 24));
    tbl.push_back(v(8'h1A, 1, 0, 0, 0, 0, 1, 24));  // error drops pending break
    tbl.push_back(v(8'h22, 0, 0, 0, 0, 0, 0, 24));  // make X == held
    tbl.push_back(v(8'h22, 0, 0, 0, 0, 0, 0, 24));

    for (int i = 0; i < tbl.size(); i++) begin
      send_frame(tbl[i].data, tbl[i].bad_par, tbl[i].bad_stop);
      chk($sformatf("vec%0d_char_valid", i), d_cv, tbl[i].cv);
      chk($sformatf("vec%0d_enter", i), d_en, tbl[i].en);
      chk($sformatf("vec%0d_backspace", i), d_bs, tbl[i].bs);
      chk($sformatf("vec%0d_frame_err", i), d_fe, tbl[i].fe);
      chk($sformatf("vec%0d_char", i), int'(char), tbl[i].ch);
      if (i == 0) chk("latency_cycles", lat, 3);
    end

    // timeout: start + 4 data bits then silence
    snap();
    send_bits(mk_bits(8'h33, 0, 0), 0, 5);
    repeat (TO + 50) @(negedge clk);
    diff();
    chk("timeout_frame_err", d_fe, 1);
    chk("timeout_char_valid", d_cv, 0);
    send_frame(8'h5A, 0, 0);
    chk("after_timeout_enter", d_en, 1);
    chk("after_timeout_err", d_fe, 0);

    // reset in the middle of a Z frame
    snap();
    fb = mk_bits(8'h1A, 0, 0);
    send_bits(fb, 0, 4);
    @(negedge clk);
    resetn = 1'b0;
    repeat (5) @(negedge clk);
    chk("midreset_char", int'(char), 0);
    resetn = 1'b1;
    send_bits(fb, 4, 11);
    repeat (TO + 50) @(negedge clk);
    diff();
    chk("midreset_char_valid", d_cv + d_en + d_bs, 0);
    chk("midreset_char_after", int'(char), 0);

    // random frames against the model; state is clean after the reset above
    m_held = 8'h00; m_f0 = 0; m_e0 = 0; m_char = 0;
    rb = 8'h00;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 9: rb = sc_tab[$urandom_range(0, 25)];
        4: rb = 8'hF0;
        5: rb = 8'hE0;
        6: rb = rb;
        7: rb = ($urandom_range(0, 1) == 0) ? 8'h5A : 8'h66;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      bad = ($urandom_range(0, 7) == 0);
      if (bad && $urandom_range(0, 1) == 0) send_frame(rb, 0, 1);
      else send_frame(rb, bad, 0);
      model(rb, bad);
      chk($sformatf("rnd%0d_b%02h_pulses", n, rb),
          d_cv * 1000 + d_en * 100 + d_bs * 10 + d_fe,
          e_cv * 1000 + e_en * 100 + e_bs * 10 + e_fe);
      chk($sformatf("rnd%0d_char", n), int'(char), m_char);
    end

    chk("one_pulse_per_cycle", n_multi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
